// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receive core: 2-flop input synchroniser, oversampling
// counters, 3-sample majority vote, LSB-first deserializer, parity and stop
// checking, and the frame state machine.
//
// Parameters
//   DATA_W  data bits per frame (5..9)
//   OVS     clk cycles per bit, even (4..32)
//
// Ports
//   clk          oversampling clock
//   ARSTn        asynchronous active-low reset
//   RX_IN        serial line, idle high, LSB first
//   PAR_EN       1 = frame carries a parity bit       (latched at frame start)
//   PAR_TYP      0 = even parity, 1 = odd parity      (latched at frame start)
//   STOP2        1 = two stop bits, 0 = one stop bit  (latched at frame start)
//   P_DATA       last good received word, held until the next good frame
//   data_valid   1-clk pulse when P_DATA is updated
//   par_err      1-clk pulse at frame end on a parity mismatch
//   stp_err      1-clk pulse at frame end when a stop bit was sampled 0
//   strt_glitch  1-clk pulse when the start bit votes high (false start)
//   busy         high whenever the frame state machine is not idle
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_W = 8,
    parameter int OVS    = 8
) (
    input  logic              clk,
    input  logic              ARSTn,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch,
    output logic              busy
);

    localparam int EW = $clog2(OVS);
    localparam int BW = 4;

    localparam logic [EW-1:0] S0_C     = EW'(OVS / 2 - 1);
    localparam logic [EW-1:0] S1_C     = EW'(OVS / 2);
    localparam logic [EW-1:0] S2_C     = EW'(OVS / 2 + 1);
    localparam logic [EW-1:0] LAST_C   = EW'(OVS - 1);
    localparam logic [EW-1:0] E_ZERO_C = {EW{1'b0}};
    localparam logic [EW-1:0] E_ONE_C  = EW'(1'b1);
    localparam logic [BW-1:0] B_ZERO_C = {BW{1'b0}};
    localparam logic [BW-1:0] B_ONE_C  = BW'(1'b1);
    localparam logic [BW-1:0] DLAST_C  = BW'(DATA_W);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    // Two-of-three majority used for every bit decision.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // High when the received parity bit disagrees with the accumulated data
    // parity corrected for the selected parity type.
    function automatic logic par_mismatch(input logic rx_bit, input logic acc, input logic odd);
        return rx_bit ^ acc ^ odd;
    endfunction

    logic              rx_meta_r, rxs_r;
    logic [2:0]        state_r, state_s;
    logic [EW-1:0]     edge_cnt_r, edge_cnt_s;
    logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
    logic              smp0_r, smp0_s, smp1_r, smp1_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic              par_acc_r, par_acc_s;
    logic              par_flag_r, par_flag_s;
    logic              stp_flag_r, stp_flag_s;
    logic              par_en_l_r, par_en_l_s;
    logic              par_typ_l_r, par_typ_l_s;
    logic              stop2_l_r, stop2_l_s;
    logic [DATA_W-1:0] p_data_r, p_data_s;
    logic              data_valid_r, data_valid_s;
    logic              par_err_r, par_err_s;
    logic              stp_err_r, stp_err_s;
    logic              strt_glitch_r, strt_glitch_s;
    logic              busy_r, busy_s;

    logic              vote_s;
    logic              at_s2_s;
    logic              at_last_s;
    logic              frame_end_s;
    logic              stp_now_s;

    // The S2 sample is taken live so the vote is ready in the S2 cycle itself.
    assign vote_s    = maj3(smp0_r, smp1_r, rxs_r);
    assign at_s2_s   = (edge_cnt_r == S2_C);
    assign at_last_s = (edge_cnt_r == LAST_C);

    // Next-state, datapath and output-pulse decode for the frame state machine.
    always_comb begin
        state_s       = state_r;
        edge_cnt_s    = edge_cnt_r;
        bit_cnt_s     = bit_cnt_r;
        smp0_s        = smp0_r;
        smp1_s        = smp1_r;
        shreg_s       = shreg_r;
        par_acc_s     = par_acc_r;
        par_flag_s    = par_flag_r;
        stp_flag_s    = stp_flag_r;
        par_en_l_s    = par_en_l_r;
        par_typ_l_s   = par_typ_l_r;
        stop2_l_s     = stop2_l_r;
        p_data_s      = p_data_r;
        data_valid_s  = 1'b0;
        par_err_s     = 1'b0;
        stp_err_s     = 1'b0;
        strt_glitch_s = 1'b0;
        frame_end_s   = 1'b0;
        stp_now_s     = stp_flag_r;

        // Oversampling counter and the two stored vote samples.
        if (state_r != ST_IDLE) begin
            edge_cnt_s = at_last_s ? E_ZERO_C : (edge_cnt_r + E_ONE_C);
            if (edge_cnt_r == S0_C) begin
                smp0_s = rxs_r;
            end else begin
                smp0_s = smp0_r;
            end
            if (edge_cnt_r == S1_C) begin
                smp1_s = rxs_r;
            end else begin
                smp1_s = smp1_r;
            end
        end else begin
            edge_cnt_s = E_ZERO_C;
        end

        case (state_r)
            ST_IDLE: begin
                bit_cnt_s = B_ZERO_C;
                if (!rxs_r) begin
                    state_s     = ST_START;
                    par_en_l_s  = PAR_EN;
                    par_typ_l_s = PAR_TYP;
                    stop2_l_s   = STOP2;
                    par_acc_s   = 1'b0;
                    par_flag_s  = 1'b0;
                    stp_flag_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (at_s2_s && vote_s) begin
                    state_s       = ST_IDLE;
                    edge_cnt_s    = E_ZERO_C;
                    strt_glitch_s = 1'b1;
                end else if (at_last_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = B_ONE_C;
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                // LSB arrives first, so shifting in from the MSB side leaves
                // bit 0 in position 0 after DATA_W bits.
                if (at_s2_s) begin
                    shreg_s   = {vote_s, shreg_r[DATA_W-1:1]};
                    par_acc_s = par_acc_r ^ vote_s;
                end else begin
                    shreg_s = shreg_r;
                end
                if (at_last_s) begin
                    bit_cnt_s = bit_cnt_r + B_ONE_C;
                    if (bit_cnt_r == DLAST_C) begin
                        state_s = par_en_l_r ? ST_PARITY : ST_STOP1;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (at_s2_s && par_mismatch(vote_s, par_acc_r, par_typ_l_r)) begin
                    par_flag_s = 1'b1;
                end else begin
                    par_flag_s = par_flag_r;
                end
                if (at_last_s) begin
                    state_s   = ST_STOP1;
                    bit_cnt_s = bit_cnt_r + B_ONE_C;
                end else begin
                    state_s = ST_PARITY;
                end
            end
            ST_STOP1: begin
                if (at_s2_s) begin
                    if (stop2_l_r) begin
                        stp_flag_s = stp_flag_r | ~vote_s;
                    end else begin
                        frame_end_s = 1'b1;
                        stp_now_s   = stp_flag_r | ~vote_s;
                    end
                end else begin
                    stp_flag_s = stp_flag_r;
                end
                if (at_last_s && stop2_l_r) begin
                    state_s   = ST_STOP2;
                    bit_cnt_s = bit_cnt_r + B_ONE_C;
                end else begin
                    state_s = ST_STOP1;
                end
            end
            ST_STOP2: begin
                if (at_s2_s) begin
                    frame_end_s = 1'b1;
                    stp_now_s   = stp_flag_r | ~vote_s;
                end else begin
                    state_s = ST_STOP2;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                edge_cnt_s = E_ZERO_C;
                bit_cnt_s  = B_ZERO_C;
            end
        endcase

        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (frame_end_s) begin
            state_s    = ST_IDLE;
            edge_cnt_s = E_ZERO_C;
            bit_cnt_s  = B_ZERO_C;
            if (par_flag_r || stp_now_s) begin
                par_err_s = par_flag_r;
                stp_err_s = stp_now_s;
            end else begin
                p_data_s     = shreg_r;
                data_valid_s = 1'b1;
            end
        end else begin
            p_data_s = p_data_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // Input synchroniser plus all state and registered outputs.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            rx_meta_r     <= 1'b1;
            rxs_r         <= 1'b1;
            state_r       <= ST_IDLE;
            edge_cnt_r    <= E_ZERO_C;
            bit_cnt_r     <= B_ZERO_C;
            smp0_r        <= 1'b0;
            smp1_r        <= 1'b0;
            shreg_r       <= {DATA_W{1'b0}};
            par_acc_r     <= 1'b0;
            par_flag_r    <= 1'b0;
            stp_flag_r    <= 1'b0;
            par_en_l_r    <= 1'b0;
            par_typ_l_r   <= 1'b0;
            stop2_l_r     <= 1'b0;
            p_data_r      <= {DATA_W{1'b0}};
            data_valid_r  <= 1'b0;
            par_err_r     <= 1'b0;
            stp_err_r     <= 1'b0;
            strt_glitch_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            rx_meta_r     <= RX_IN;
            rxs_r         <= rx_meta_r;
            state_r       <= state_s;
            edge_cnt_r    <= edge_cnt_s;
            bit_cnt_r     <= bit_cnt_s;
            smp0_r        <= smp0_s;
            smp1_r        <= smp1_s;
            shreg_r       <= shreg_s;
            par_acc_r     <= par_acc_s;
            par_flag_r    <= par_flag_s;
            stp_flag_r    <= stp_flag_s;
            par_en_l_r    <= par_en_l_s;
            par_typ_l_r   <= par_typ_l_s;
            stop2_l_r     <= stop2_l_s;
            p_data_r      <= p_data_s;
            data_valid_r  <= data_valid_s;
            par_err_r     <= par_err_s;
            stp_err_r     <= stp_err_s;
            strt_glitch_r <= strt_glitch_s;
            busy_r        <= busy_s;
        end
    end

    assign P_DATA      = p_data_r;
    assign data_valid  = data_valid_r;
    assign par_err     = par_err_r;
    assign stp_err     = stp_err_r;
    assign strt_glitch = strt_glitch_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (DATA_W=8, OVS=8). Frames are built
// bit by bit from a record; the expected outcome and its cycle come from the
// frame rules (parity by ones count, stop bits, frame length arithmetic).
module tb_uart_rx_param;
    localparam int DW = 8;
    localparam int OV = 8;

    logic          clk = 1'b0;
    logic          ARSTn, RX_IN, PAR_EN, PAR_TYP, STOP2;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stp_err, strt_glitch, busy;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_pdata;

    typedef struct {
        int            cyc;
        logic [3:0]    fl;   // {data_valid, par_err, stp_err, strt_glitch}
        logic [DW-1:0] pd;
    } ev_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          pen, ptyp, st2, flip, s1, s2;
        int            gap;
        logic          dv, pe, se;
    } vec_t;

    ev_t ev_q[$];
    ev_t exp_q[$];

    uart_rx_param #(.DATA_W(DW), .OVS(OV)) dut (
        .clk(clk), .ARSTn(ARSTn), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP), .STOP2(STOP2), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err),
        .strt_glitch(strt_glitch), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse with its cycle number, sampled mid-cycle.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (data_valid || par_err || stp_err || strt_glitch) begin
                e.cyc = cyc;
                e.fl  = {data_valid, par_err, stp_err, strt_glitch};
                e.pd  = P_DATA;
                ev_q.push_back(e);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, actual running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    task automatic drive_bit(input logic b);
        RX_IN = b;
        repeat (OV) tick();
    endtask

    // A bad stop bit is low through its sample window but back high for its
    // last cycle, so the line is idle when the receiver returns to IDLE.
    task automatic drive_stop(input logic b);
        if (b) begin
            drive_bit(1'b1);
        end else begin
            RX_IN = 1'b0;
            repeat (OV - 1) tick();
            RX_IN = 1'b1;
            tick();
        end
    endtask

    function automatic vec_t mk(input logic [DW-1:0] d, input logic pen, input logic ptyp,
                                input logic st2, input logic flip, input logic s1,
                                input logic s2, input int gap, input logic dv,
                                input logic pe, input logic se);
        vec_t v;
        v.data = d; v.pen = pen; v.ptyp = ptyp; v.st2 = st2; v.flip = flip;
        v.s1 = s1; v.s2 = s2; v.gap = gap; v.dv = dv; v.pe = pe; v.se = se;
        return v;
    endfunction

    // Parity bit placed on the line: the correct one unless flip is set.
    function automatic logic par_sent(input vec_t v);
        logic correct;
        correct = (($countones(v.data) % 2) == 1) ^ v.ptyp;
        return correct ^ v.flip;
    endfunction

    // Reference outcome: even parity wants an even number of ones over data
    // plus parity bit, odd parity an odd number; any stop bit at 0 is an error.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   ones;
        r    = v;
        ones = $countones(v.data) + int'(par_sent(v));
        r.pe = v.pen && ((ones % 2) != int'(v.ptyp));
        r.se = !v.s1 || (v.st2 && !v.s2);
        r.dv = !r.pe && !r.se;
        return r;
    endfunction

    task automatic send_frame(input vec_t v);
        int  e0;
        int  lst;
        ev_t x;
        RX_IN = 1'b1;
        repeat (v.gap) tick();
        e0      = cyc;
        PAR_EN  = v.pen;
        PAR_TYP = v.ptyp;
        STOP2   = v.st2;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) begin
            drive_bit(v.data[i]);
            if (i == 1) begin
                PAR_EN  = 1'($urandom_range(0, 1));
                PAR_TYP = 1'($urandom_range(0, 1));
                STOP2   = 1'($urandom_range(0, 1));
            end
        end
        if (v.pen) drive_bit(par_sent(v));
        drive_stop(v.s1);
        if (v.st2) drive_stop(v.s2);
        lst   = DW + int'(v.pen) + 1 + int'(v.st2);
        x.cyc = e0 + 3 + lst * OV + OV / 2 + 2;
        x.fl  = {v.dv, v.pe, v.se, 1'b0};
        if (v.dv) exp_pdata = v.data;
        x.pd  = exp_pdata;
        exp_q.push_back(x);
    endtask

    task automatic compare_events(input string tag);
        ev_t a, x;
        int  k;
        k = 0;
        RX_IN = 1'b1;
        repeat (20) tick();
        chk({tag, " pulse count"}, 64'(ev_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && ev_q.size() > 0) begin
            x = exp_q.pop_front();
            a = ev_q.pop_front();
            chk($sformatf("%s[%0d] cycle", tag, k), 64'(a.cyc), 64'(x.cyc));
            chk($sformatf("%s[%0d] flags", tag, k), 64'(a.fl), 64'(x.fl));
            chk($sformatf("%s[%0d] P_DATA", tag, k), 64'(a.pd), 64'(x.pd));
            k++;
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t          dir[8];
        vec_t          v;
        int            e0;
        logic [DW-1:0] b55;
        ev_t           x;

        ARSTn = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        exp_pdata = {DW{1'b0}};

        //           data   pen   typ   st2   flip  s1    s2  gap  dv    pe    se
        dir[0] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        dir[1] = mk(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b1, 1'b0);
        dir[2] = mk(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b1);
        dir[3] = mk(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  5, 1'b1, 1'b0, 1'b0);
        dir[4] = mk(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,  0, 1'b1, 1'b0, 1'b0);
        dir[5] = mk(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,  0, 1'b0, 1'b0, 1'b1);
        dir[6] = mk(8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b1);
        dir[7] = mk(8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,  4, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("outputs in reset", 64'({P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}), 64'd0);
        tick();
        ARSTn = 1'b1;
        repeat (5) tick();
        chk("outputs after release", 64'({P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}), 64'd0);

        // Directed table, including back-to-back two-stop frames.
        for (int i = 0; i < 8; i++) send_frame(dir[i]);
        compare_events("dir");

        // False start: line low for two clocks only.
        repeat (5) tick();
        e0 = cyc;
        RX_IN = 1'b0;
        tick();
        tick();
        RX_IN = 1'b1;
        wait_neg(e0 + 2);
        chk("busy before T0", 64'(busy), 64'd0);
        wait_neg(e0 + 3);
        chk("busy at T0", 64'(busy), 64'd1);
        wait_neg(e0 + 8);
        chk("busy before glitch", 64'(busy), 64'd1);
        wait_neg(e0 + 9);
        chk("busy at glitch", 64'(busy), 64'd0);
        x.cyc = e0 + 9;
        x.fl  = 4'b0001;
        x.pd  = exp_pdata;
        exp_q.push_back(x);
        tick();
        compare_events("glitch");

        // Random frames against the reference outcome.
        for (int r = 0; r < 24; r++) begin
            v.data = DW'($urandom);
            v.pen  = 1'($urandom_range(0, 1));
            v.ptyp = 1'($urandom_range(0, 1));
            v.st2  = 1'($urandom_range(0, 1));
            v.flip = ($urandom_range(0, 3) == 0);
            v.s1   = ($urandom_range(0, 4) != 0);
            v.s2   = ($urandom_range(0, 4) != 0);
            v.gap  = int'($urandom_range(0, 4));
            send_frame(predict(v));
        end
        compare_events("rand");

        // Reset in the middle of the data bits of frame 0x55.
        b55 = 8'h55;
        PAR_EN = 1'b1; PAR_TYP = 1'b0; STOP2 = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b55[i]);
        ARSTn = 1'b0;
        RX_IN = 1'b1;
        @(negedge clk);
        chk("outputs in mid-frame reset", 64'({P_DATA, data_valid, par_err, stp_err, strt_glitch, busy}), 64'd0);
        repeat (3) tick();
        ARSTn = 1'b1;
        repeat (30) tick();
        exp_pdata = {DW{1'b0}};
        compare_events("abort");
        chk("P_DATA after reset", 64'(P_DATA), 64'd0);
        send_frame(mk(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0));
        compare_events("post-reset");
        chk("P_DATA final", 64'(P_DATA), 64'h12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
